// File: rtl/saper_pkg.sv
// rtl/saper_pkg.sv - shared board constants and placer state type
package saper_pkg;

  localparam int BOARD_MAX = 16;
  localparam int MAP_BITS  = BOARD_MAX * BOARD_MAX;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PLACE = 2'd2,
    DONE  = 2'd3
  } placer_state_t;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR exposing its low byte
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] sample
);

  logic [15:0] state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEED;
    else        state <= {1'b0, state[15:1]} ^ (state[0] ? TAPS : 16'h0000);
  end

  assign sample = state[7:0];

endmodule

// File: rtl/mine_placer.sv
// rtl/mine_placer.sv - places the level's mines on the board by LFSR rejection
// sampling and serves registered per-cell mine queries
module mine_placer
  import saper_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] mines_in,
  input  logic [4:0] button_num,
  input  logic [3:0] query_x,
  input  logic [3:0] query_y,
  output logic       query_mine,
  output logic       busy,
  output logic       done,
  output logic [5:0] mines_placed
);

  placer_state_t       state;
  logic [7:0]          rnd;
  logic [MAP_BITS-1:0] map;
  logic [4:0]          n_eff, n_eff_q;
  logic [8:0]          cells, limit;
  logic [5:0]          target_next, target_q;
  logic [7:0]          cand_idx;
  logic                cand_ok;

  lfsr16 #(.SEED(LFSR_SEED), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (rnd)
  );

  // A zero-sized board has no free cell to spare, so it gets no mines at all.
  always_comb begin
    n_eff       = (button_num > 5'(BOARD_MAX)) ? 5'(BOARD_MAX) : button_num;
    cells       = 9'(n_eff) * 9'(n_eff);
    limit       = (cells == 9'd0) ? 9'd0 : cells - 9'd1;
    target_next = ({3'b000, mines_in} < limit) ? mines_in : limit[5:0];
    cand_idx    = rnd;
    cand_ok     = ({1'b0, rnd[3:0]} < n_eff_q) && ({1'b0, rnd[7:4]} < n_eff_q)
                  && !map[cand_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      map          <= '0;
      mines_placed <= '0;
      n_eff_q      <= '0;
      target_q     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            n_eff_q  <= n_eff;
            target_q <= target_next;
            state    <= CLEAR;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        CLEAR: begin
          map          <= '0;
          mines_placed <= '0;
          if (target_q == 6'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= PLACE;
          end
        end
        PLACE: begin
          if (cand_ok) begin
            map[cand_idx] <= 1'b1;
            mines_placed  <= mines_placed + 6'd1;
            if (mines_placed + 6'd1 == target_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) query_mine <= 1'b0;
    else        query_mine <= map[{query_y, query_x}];
  end

endmodule

// File: tb/tb_mine_placer.sv
// tb/tb_mine_placer.sv - randomized directed bench for mine_placer against a
// board-level reference model
module tb_mine_placer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] mines_in;
  logic [4:0] button_num;
  logic [3:0] query_x, query_y;
  logic       query_mine, busy, done;
  logic [5:0] mines_placed;

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] model_lfsr;

  mine_placer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mines_in     (mines_in),
    .button_num   (button_num),
    .query_x      (query_x),
    .query_y      (query_y),
    .query_mine   (query_mine),
    .busy         (busy),
    .done         (done),
    .mines_placed (mines_placed)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_lfsr <= 16'hACE1;
    else        model_lfsr <= lfsr_step(model_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Plays out a whole placement from the LFSR value seen at the start edge.
  task automatic predict(input logic [15:0] l0, input int mines, input int bn,
                         output logic [255:0] m, output int tgt, output int done_cyc,
                         output int first_cell, output int first_cyc);
    int n, placed, x, y;
    logic [15:0] l;
    n   = (bn > 16) ? 16 : bn;
    tgt = (n == 0) ? 0 : ((mines < n * n - 1) ? mines : n * n - 1);
    m = '0;
    placed = 0;
    first_cell = 0;
    first_cyc = 0;
    l = lfsr_step(lfsr_step(l0));
    done_cyc = 2;
    while (placed < tgt && done_cyc < 100000) begin
      x = int'(l[3:0]);
      y = int'(l[7:4]);
      if (x < n && y < n && !m[y * 16 + x]) begin
        if (placed == 0) begin
          first_cell = y * 16 + x;
          first_cyc  = done_cyc;
        end
        m[y * 16 + x] = 1'b1;
        placed++;
      end
      l = lfsr_step(l);
      done_cyc++;
    end
  endtask

  task automatic sweep(input logic [255:0] m, input string tag);
    int ones = 0;
    int exp_ones = 0;
    for (int c = 0; c < 256; c++) begin
      query_x = 4'(c % 16);
      query_y = 4'(c / 16);
      @(posedge clk); #1;
      check(tag, 32'(query_mine), 32'(m[c]));
      if (query_mine === 1'b1) ones++;
      if (m[c]) exp_ones++;
    end
    check({tag, "_count"}, 32'(ones), 32'(exp_ones));
  endtask

  task automatic run_game(input int mines, input int bn, input int idle,
                          input bit inject, input bit watch);
    logic [255:0] pm;
    int tgt, pc, fcell, fcyc, cyc;
    for (int i = 0; i < idle; i++) begin
      @(posedge clk); #1;
    end
    mines_in   = 6'(mines);
    button_num = 5'(bn);
    start      = 1'b1;
    predict(model_lfsr, mines, bn, pm, tgt, pc, fcell, fcyc);
    if (watch) begin
      query_x = 4'(fcell % 16);
      query_y = 4'(fcell / 16);
    end
    @(posedge clk); #1;
    start      = 1'b0;
    mines_in   = 6'($urandom);
    button_num = 5'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 3000) begin
      check("busy_while_placing", 32'(busy), 32'd1);
      if (watch && tgt > 0 && cyc >= 3)
        check("query_timing", 32'(query_mine), 32'(cyc >= fcyc + 2));
      if (inject && cyc == 4) begin
        start      = 1'b1;
        mines_in   = 6'd5;
        button_num = 5'd8;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("done_cycle", 32'(cyc), 32'(pc));
    check("done_level", 32'(done), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("mines_placed", 32'(mines_placed), 32'(tgt));
    if (watch && tgt > 0)
      check("query_timing_end", 32'(query_mine), 32'(cyc >= fcyc + 2));
    sweep(pm, "map_cell");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_query_mine"}, 32'(query_mine), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_mines_placed"}, 32'(mines_placed), 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n      = 1'b0;
    start      = 1'b0;
    mines_in   = '0;
    button_num = '0;
    query_x    = '0;
    query_y    = '0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    run_game(8, 8, $urandom_range(1, 40), 1'b0, 1'b1);
    run_game(60, 16, $urandom_range(0, 20), 1'b1, 1'b0);
    run_game(0, 10, $urandom_range(0, 9), 1'b0, 1'b0);
    run_game(63, 4, $urandom_range(0, 9), 1'b0, 1'b0);
    run_game(5, 0, $urandom_range(0, 9), 1'b0, 1'b0);
    run_game(40, 31, $urandom_range(0, 9), 1'b0, 1'b1);

    mines_in   = 6'd60;
    button_num = 5'd16;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (mines_placed !== 6'd3 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_three_mines", 32'(mines_placed), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_place_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sweep('0, "post_reset_cell");
    run_game(20, 10, $urandom_range(1, 30), 1'b0, 1'b1);

    for (int g = 0; g < 4; g++)
      run_game($urandom_range(0, 63), $urandom_range(0, 20), $urandom_range(0, 15),
               1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mine_placer.md
# mine_placer

Randomly places the level's mine count on the active board once difficulty has been chosen, and holds the resulting mine map for the rest of the game. Sits directly after the level-selection stage: it consumes that stage's one-cycle config pulse, mine count and board dimension, then serves per-cell mine queries to the board drawing and click-handling logic. Placement uses a free-running LFSR with rejection sampling, evaluating one candidate per clock.

## Interface
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- BOARD_MAX, 16, maximum cells per side; fixes the map at 256 bits.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from level selection (its level_enable) meaning the config inputs are valid.
- mines_in  in  6  requested mine count.
- button_num  in  5  cells per board side (8, 10 or 16 in normal use).
- query_x, query_y  in  4 each  column and row of the cell being queried.
- query_mine  out  1  registered: 1 if a mine occupies (query_x, query_y).
- busy  out  1  high during CLEAR and PLACE.
- done  out  1  level signal, high while in DONE.
- mines_placed  out  6  running count of mines placed.

## Operation
- States: IDLE, CLEAR, PLACE, DONE. State is encoded as a 2-bit enum.
- IDLE -> CLEAR on start. DONE -> CLEAR on start (new game). start is ignored in CLEAR and PLACE.
- On an accepted start the block latches the config:
  - n_eff = min(button_num, 16).
  - target = min(mines_in, n_eff*n_eff - 1). One cell is always left free.
- CLEAR (1 cycle): zero all 256 map bits and set mines_placed = 0.
  - If target == 0, go to DONE; otherwise go to PLACE.
- PLACE (one candidate per cycle): candidate x = lfsr[3:0], y = lfsr[7:4].
  - Reject the candidate if x >= n_eff, y >= n_eff, or map[{y,x}] is already set.
  - Otherwise set map[{y,x}] and increment mines_placed.
  - When mines_placed reaches target (on the accepting cycle), the next state is DONE.
- DONE: the map is held, done = 1, busy = 0.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400).
  - Advances every cycle in every state, so the seed sequence depends on how long the player waits before starting.
  - The maximal period guarantees every (x,y) pair recurs, so PLACE always terminates.
- Query port:
  - query_mine <= map[{query_y,query_x}] every cycle, in every state.
  - Out-of-range coordinates read 0 after a clear.
- Arithmetic:
  - n_eff*n_eff is computed at 9 bits (max 256).
  - The comparison with the 6-bit mines_in is zero-extended.

## Timing
- Reset values:
  - State IDLE, map all 0, query_mine 0, busy 0, done 0, mines_placed 0.
  - LFSR = LFSR_SEED.
- Placement latency:
  - start is sampled at edge 0; CLEAR is active in cycle 1; PLACE is evaluated from cycle 2.
  - With no rejections, done rises at cycle target+2. The minimum for level 1 (8 mines) is therefore 10 cycles.
- mines_placed updates on the same edge as the map bit it counts.
- Query latency is 1 cycle.
  - A query issued in the cycle a bit is written returns the old value.
  - The new value is visible one cycle later.
- Reset mid-PLACE: the map is cleared immediately (asynchronously) and the block returns to IDLE; a fresh start is required.
- start coincident with reset deassertion is not captured; start must be pulsed after rst_n has been high for at least 1 cycle.

## Structure
- Shared package saper_pkg:
  - BOARD_MAX and MAP_BITS (256).
  - LFSR_TAPS (16'hB400).
  - The placer state typedef (IDLE/CLEAR/PLACE/DONE).
- Sub-module lfsr16: contains the free-running Galois LFSR, parameterised by seed and taps, with async active-low reset.
- The top level holds the FSM, the config latch, the 256-bit map register, the placement counter and the query read register.

## Test plan
- Level 1 (start pulse, mines_in=8, button_num=8):
  - done rises within a bounded time (assert < 2000 cycles).
  - mines_placed=8.
  - A sweep of all 256 query cells counts exactly 8 ones, all with x<8 and y<8.
- Level 3 (mines_in=60, button_num=16):
  - Exactly 60 distinct mines.
  - busy stays high from cycle 1 until the cycle done rises.
- Boundaries:
  - mines_in=0, button_num=10: done at cycle 2 and the map is all zero.
  - mines_in=63, button_num=4: target clamps to 15, so 15 mines are placed and 1 cell stays clear.
  - button_num=0: done at cycle 2 with 0 mines.
- Reset mid-PLACE:
  - Assert rst_n=0 after 3 mines are placed; all outputs reach reset values immediately.
  - A full sweep reads 0.
  - A later start with level 2 parameters (mines_in=20, button_num=10) places 20 mines.
- start during PLACE is ignored: the final count matches the first config. start in DONE clears the map and re-places with the new config.
- Query timing: continuously query a cell; query_mine goes 1 exactly 1 cycle after the mines_placed increment that wrote that cell.
